// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-channel key debouncer.
// Each active-low raw key is synchronized through two flops and filtered by a
// per-channel four-state FSM (IDLE, PRESS_FLT, DOWN, REL_FLT). The filter
// counter must see DELAY_10MS consecutive stable samples before a press or
// release is accepted. Press/release are one-cycle pulses; key_state is the
// debounced level (1 = pressed).
// Optional feature macro: KEY_LONG_PRESS_EN adds a key_long pulse fired once
// per press after LONG_CNT filter periods spent in the pressed state.

module key_debounce_lane #(
    parameter int DELAY_10MS = 500000,
    parameter int CNT_W      = 20
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_CNT   = 100
`endif
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_FLT = 2'd1,
        DOWN      = 2'd2,
        REL_FLT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_10MS - 1);

    logic [1:0]       sync_q, sync_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             ks;
    logic             cnt_hit;

    // Two-flop synchronizer; resets to the released (high) level.
    always_comb begin
        sync_d = {sync_q[0], key_raw};
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) sync_q <= 2'b11;
        else          sync_q <= sync_d;
    end

    assign ks      = sync_q[1];
    assign cnt_hit = (cnt_q == CNT_MAX);

    // Filter FSM: counter is cleared on every state entry and only compared
    // for equality, so it cannot run past CNT_MAX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ks) begin
                    state_d = PRESS_FLT;
                    cnt_d   = '0;
                end
            end
            PRESS_FLT: begin
                if (ks) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_hit) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (ks) begin
                    state_d = REL_FLT;
                    cnt_d   = '0;
                end
`ifdef KEY_LONG_PRESS_EN
                // While held, the counter free-runs modulo DELAY_10MS to mark
                // long-press periods.
                else if (cnt_hit) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            REL_FLT: begin
                if (!ks) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_hit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, filter counter and pulse registers.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Debounced level follows the FSM, so it changes in the same cycle as
    // the press/release pulse.
    assign key_state   = (state_q == DOWN) || (state_q == REL_FLT);
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [7:0] LONG_MAX = 8'(LONG_CNT);

    logic [7:0] period_q, period_d;
    logic       long_q, long_d;

    // Period counter: restarts on a fresh press, advances on each DOWN wrap,
    // saturates at LONG_CNT so only one key_long fires per press.
    always_comb begin
        period_d = period_q;
        long_d   = 1'b0;
        if (state_q == PRESS_FLT && state_d == DOWN) begin
            period_d = '0;
        end else if (state_q == DOWN && !ks && cnt_hit && period_q != LONG_MAX) begin
            period_d = period_q + 8'd1;
            long_d   = (period_q == LONG_MAX - 8'd1);
        end
    end

    // Long-press period counter and pulse register.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            period_q <= '0;
            long_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            long_q   <= long_d;
        end
    end

    assign key_long = long_q;
`endif

endmodule

module key_debounce_multi #(
    parameter int KEY_NUM    = 4,
    parameter int DELAY_10MS = 500000,
    parameter int CNT_W      = 20,
    parameter int LONG_CNT   = 100
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic [KEY_NUM-1:0] key_long
`endif
);

    // Elaboration-time parameter legality checks.
    generate
        if (KEY_NUM < 1 || KEY_NUM > 16) begin : g_bad_key_num
            $error("key_debounce_multi: KEY_NUM out of range 1..16");
        end
        if (DELAY_10MS < 2 || DELAY_10MS > (1 << CNT_W) - 1) begin : g_bad_delay
            $error("key_debounce_multi: DELAY_10MS out of range");
        end
        if (LONG_CNT < 1 || LONG_CNT > 255) begin : g_bad_long
            $error("key_debounce_multi: LONG_CNT out of range 1..255");
        end
    endgenerate

    // One fully independent debounce lane per key.
    generate
        for (genvar g = 0; g < KEY_NUM; g++) begin : g_lane
            key_debounce_lane #(
                .DELAY_10MS (DELAY_10MS),
                .CNT_W      (CNT_W)
`ifdef KEY_LONG_PRESS_EN
                ,
                .LONG_CNT   (LONG_CNT)
`endif
            ) u_lane (
                .sclk        (sclk),
                .s_rst_n     (s_rst_n),
                .key_raw     (key[g]),
                .key_state   (key_state[g]),
                .key_press   (key_press[g]),
                .key_release (key_release[g])
`ifdef KEY_LONG_PRESS_EN
                ,
                .key_long    (key_long[g])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi (KEY_NUM=4, DELAY_10MS=110, LONG_CNT=3).
// Expected pulses are queued as {cycle, channel, kind} when stimulus is
// driven; every cycle the due entries are popped and all outputs compared.

module tb_key_debounce_multi;

    localparam int KN  = 4;
    localparam int DLY = 110;
    localparam int LAT = DLY + 3;   // key change to pulse, in rising edges
    localparam int LC  = 3;

    logic          sclk = 1'b0;
    logic          s_rst_n;
    logic [KN-1:0] key;
    logic [KN-1:0] key_state, key_press, key_release;
`ifdef KEY_LONG_PRESS_EN
    logic [KN-1:0] key_long;
`endif

    key_debounce_multi #(
        .KEY_NUM    (KN),
        .DELAY_10MS (DLY),
        .CNT_W      (20),
        .LONG_CNT   (LC)
    ) dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .key         (key),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release)
`ifdef KEY_LONG_PRESS_EN
        ,
        .key_long    (key_long)
`endif
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 long
    } ev_t;

    typedef struct {
        logic [KN-1:0] mask;      // channels driven low
        int            low_len;   // cycles held low
        bit            exp_press; // expect press + release pulses
    } vec_t;

    ev_t           q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [KN-1:0] exp_state = '0;

    task automatic chk(input string name, input logic [KN-1:0] act, input logic [KN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int at, input logic [KN-1:0] mask, input int kind);
        for (int c = 0; c < KN; c++)
            if (mask[c]) q.push_back('{at, c, kind});
    endtask

    // Advance one clock, pop events due this cycle and compare all outputs.
    task automatic step();
        logic [KN-1:0] ep, er, el;
        @(posedge sclk);
        cyc++;
        #1;
        ep = '0; er = '0; el = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    0:       ep[q[i].ch] = 1'b1;
                    1:       er[q[i].ch] = 1'b1;
                    default: el[q[i].ch] = 1'b1;
                endcase
                q.delete(i);
            end
        end
        exp_state = (exp_state | ep) & ~er;
        chk("press",   key_press,   ep);
        chk("release", key_release, er);
        chk("state",   key_state,   exp_state);
        chk("press_and_release", key_press & key_release, '0);
`ifdef KEY_LONG_PRESS_EN
        chk("long",    key_long,    el);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle reset pulse: aborts everything in flight without pulses.
    task automatic reset_pulse();
        s_rst_n   = 1'b0;
        q.delete();
        exp_state = '0;
        step();
        s_rst_n   = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'b0010,  50, 1'b0};  // short bounce: nothing
        vecs[1] = '{4'b0001, 110, 1'b0};  // one cycle short of the filter
        vecs[2] = '{4'b0001, 111, 1'b1};  // shortest accepted press
        vecs[3] = '{4'b1100, 150, 1'b1};  // simultaneous channels 2,3
        vecs[4] = '{4'b0101, 200, 1'b1};
        vecs[5] = '{4'b1111, 120, 1'b1};

        // Reset, then idle keys: all outputs stay 0.
        key     = '1;
        s_rst_n = 1'b0;
        steps(3);
        s_rst_n = 1'b1;
        steps(200);

        // Noisy press / noisy release on channel 0, quiet elsewhere.
        for (int i = 0; i < 99; i++) begin
            key[0] = 1'($urandom_range(0, 1));
            step();
        end
        key[0] = 1'b1;
        step();
        key[0] = 1'b0;
        push(cyc + LAT, 4'b0001, 0);
        steps(300);
        for (int i = 0; i < 99; i++) begin
            key[0] = 1'($urandom_range(0, 1));
            step();
        end
        key[0] = 1'b0;
        step();
        key[0] = 1'b1;
        push(cyc + LAT, 4'b0001, 1);
        steps(130);

        // Table-driven clean presses of various lengths and channel sets.
        for (int r = 0; r < 6; r++) begin
            key = ~vecs[r].mask;
            if (vecs[r].exp_press) push(cyc + LAT, vecs[r].mask, 0);
            steps(vecs[r].low_len);
            key = '1;
            if (vecs[r].exp_press) push(cyc + LAT, vecs[r].mask, 1);
            steps(130);
        end

        // Release bounce one cycle short of the filter: stays pressed.
        key = 4'b1110;
        push(cyc + LAT, 4'b0001, 0);
        steps(150);
        key = 4'b1111;
        steps(DLY);
        key = 4'b1110;
        steps(60);
        key = 4'b1111;
        push(cyc + LAT, 4'b0001, 1);
        steps(130);

        // Reset while held in DOWN: no release, fresh press after reset.
        key = 4'b1110;
        push(cyc + LAT, 4'b0001, 0);
        steps(150);
        reset_pulse();
        push(cyc + LAT, 4'b0001, 0);
        steps(150);
        key = 4'b1111;
        push(cyc + LAT, 4'b0001, 1);
        steps(130);

`ifdef KEY_LONG_PRESS_EN
        // Long hold: one key_long LONG_CNT periods after the press.
        key = 4'b1110;
        push(cyc + LAT, 4'b0001, 0);
        push(cyc + LAT + LC * DLY, 4'b0001, 2);
        steps(600);
        key = 4'b1111;
        push(cyc + LAT, 4'b0001, 1);
        steps(130);
`endif

        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events left=%0d", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
